mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares one single-ported instruction/data memory between the fetch port (pc_address) and the
// EX/MEM data port (memread/memwrite) of the 5-stage RISC_V_processor. It sequences each access
// over a req/ack memory handshake, returns read data to the winner, and raises stall_pipe so the
// PC and all pipeline registers (enable inputs) freeze while any access is outstanding.
// PARAMETERS
// DATA_W       32   data and address width
// STARVE_MAX   4    consecutive data grants allowed while a fetch is waiting; next grant is forced to fetch
// TIMEOUT      16   cycles mem_req may stay unacknowledged before the access is aborted
// PORTS
// clk          in   1       system clock, all state on rising edge
// reset        in   1       synchronous, active-high
// if_req       in   1       fetch request; held until if_ready
// if_addr      in   DATA_W  fetch address (pc_address)
// if_rdata     out  DATA_W  fetched instruction, valid while if_ready=1
// if_ready     out  1       one-cycle completion pulse, fetch
// d_read       in   1       data load request (exmem memread); held until d_ready
// d_write      in   1       data store request (exmem memwrite); held until d_ready
// d_addr       in   DATA_W  data address
// d_wdata      in   DATA_W  store data
// d_rdata      out  DATA_W  load data, valid while d_ready=1
// d_ready      out  1       one-cycle completion pulse, data
// mem_req      out  1       memory access request
// mem_we       out  1       1 = write, 0 = read
// mem_addr     out  DATA_W  memory address
// mem_wdata    out  DATA_W  memory write data
// mem_rdata    in   DATA_W  memory read data, valid in the mem_ack cycle
// mem_ack      in   1       one-cycle completion from memory
// stall_pipe   out  1       freeze PC/IF-ID/ID-EX/EX-MEM/MEM-WB
// bus_error    out  1       sticky: a timeout occurred
// BEHAVIOUR
// - Reset: state=IDLE; mem_req, mem_we, if_ready, d_ready, bus_error = 0; mem_addr, mem_wdata,
//   if_rdata, d_rdata = 0; starve counter and timeout counter = 0. Reset mid-access abandons it; any
//   late mem_ack is ignored.
// - FSM IDLE -> GRANT_D | GRANT_F -> RESP -> IDLE.
// - IDLE: d_req = d_read|d_write. d_req & (~if_req | starve<STARVE_MAX) -> GRANT_D, starve +=1 if if_req
//   else starve=0. Else if_req -> GRANT_F, starve=0. Address/wdata/we latched on this edge.
// - d_read & d_write together: treated as write (mem_we=1), d_rdata=0.
// - GRANT_*: mem_req=1 with mem_addr/mem_we/mem_wdata stable until mem_ack. On mem_ack, mem_rdata
//   registered into the winner's rdata, -> RESP. Timeout counter increments each unacked cycle;
//   reaching TIMEOUT -> RESP with rdata=0, bus_error<=1.
// - RESP: winner's ready=1 for exactly this cycle, mem_req=0; -> IDLE next edge. Minimum latency:
//   request seen at cycle N, mem_req at N+1, ack at N+1 (zero-wait memory), ready at N+2.
// - Back-to-back: a fresh request is only arbitrated in IDLE (one idle cycle between accesses).
// - Requester dropping its request mid-access: access completes on the memory side; ready pulse still
//   issued, caller ignores it. No abort to memory.
// - stall_pipe = (if_req & ~if_ready) | (d_req & ~d_ready), combinational; 0 in reset.
// - mem_ack outside GRANT_* ignored. Counters saturate, never wrap.
// STRUCTURE
// - Shared package: state encoding localparams (ST_IDLE, ST_GRANT_D, ST_GRANT_F, ST_RESP), owner
//   encoding OWN_F/OWN_D, default STARVE_MAX/TIMEOUT.
// - One sub-module is natural: arb_timeout_counter (load/clear/increment, saturating, terminal flag).
// - Everything else flat: FSM, latch registers, starve counter, output decode.
// TESTING
// - Fetch only, if_addr=0x40, mem_ack 2 cycles after mem_req, mem_rdata=0x00500093 -> if_ready
//   1 cycle, if_rdata=0x00500093, stall_pipe high from request until ready.
// - Simultaneous if_req and d_read @0x1000 -> data granted first (mem_we=0, mem_addr=0x1000),
//   fetch follows after RESP+IDLE.
// - Continuous d_write plus held if_req -> after 4 data grants the 5th grant is fetch; starve cleared.
// - No mem_ack for 16 cycles on a load -> d_ready pulse, d_rdata=0, bus_error=1 until reset.
// - reset asserted while in GRANT_D, then late mem_ack -> all outputs 0, no ready pulse, state IDLE.
// - d_read & d_write both high, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, d_rdata=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_D = 2'd1,
        ST_GRANT_F = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int unsigned DEF_STARVE_MAX = 4;
    localparam int unsigned DEF_TIMEOUT    = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the pipeline ports, the arbiter and the shared memory.
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              if_req;
    logic [DATA_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              d_read;
    logic              d_write;
    logic [DATA_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    // Arbiter side: serves the pipeline ports, masters the memory bus.
    modport master (
        input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Saturating count of unacknowledged request cycles; 'last' marks the LIMIT-th such cycle.
module arb_timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic last
);
    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] MAX_CNT  = W'(LIMIT);
    localparam logic [W-1:0] LAST_CNT = W'(LIMIT - 1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (incr && (count_q != MAX_CNT)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign last = (count_q >= LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data port,
// one access at a time, with fetch-starvation limit and access timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus,
    output logic               stall_pipe,
    output logic               bus_error
);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    state_e            state_q;
    owner_e            owner_q;
    logic [SW-1:0]     starve_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_ready_q;
    logic              d_ready_q;
    logic              bus_error_q;
    logic              d_req;
    logic              in_grant;
    logic              tmo_last;

    assign d_req    = bus.d_read | bus.d_write;
    assign in_grant = (state_q == ST_GRANT_D) || (state_q == ST_GRANT_F);

    arb_timeout_counter #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clear (!in_grant),
        .incr  (in_grant && !bus.mem_ack),
        .last  (tmo_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_F;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // Data wins unless fetch has already waited through STARVE_MAX data grants.
                    if (d_req && (!bus.if_req || (starve_q < STARVE_LIM))) begin
                        state_q     <= ST_GRANT_D;
                        owner_q     <= OWN_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_write;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                        if (!bus.if_req) begin
                            starve_q <= '0;
                        end else if (starve_q != STARVE_LIM) begin
                            starve_q <= starve_q + SW'(1);
                        end
                    end else if (bus.if_req) begin
                        state_q     <= ST_GRANT_F;
                        owner_q     <= OWN_F;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                        starve_q    <= '0;
                    end
                end
                ST_GRANT_D, ST_GRANT_F: begin
                    if (bus.mem_ack || tmo_last) begin
                        state_q   <= ST_RESP;
                        mem_req_q <= 1'b0;
                        if (!bus.mem_ack) begin
                            bus_error_q <= 1'b1;
                        end
                        if (owner_q == OWN_D) begin
                            d_ready_q <= 1'b1;
                            d_rdata_q <= (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;
                        end else begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= bus.mem_ack ? bus.mem_rdata : '0;
                        end
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus_error     = bus_error_q;

    assign stall_pipe = !reset && ((bus.if_req && !if_ready_q) || (d_req && !d_ready_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    localparam int unsigned DW   = 32;
    localparam int unsigned SMAX = 4;
    localparam int unsigned TMO  = 16;

    typedef struct {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall_pipe;
    logic bus_error;

    int n_checks = 0;
    int n_fail = 0;
    int m_starve = 0;
    bit ack_en = 1'b1;
    bit force_ack = 1'b0;
    int delay_q[$];
    acc_t log_q[$];
    logic [DW-1:0] phys_mem[logic [DW-1:0]];
    logic [DW-1:0] ref_mem[logic [DW-1:0]];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .DATA_W     (DW),
        .STARVE_MAX (SMAX),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .stall_pipe (stall_pipe),
        .bus_error  (bus_error)
    );

    function automatic logic [DW-1:0] mem_init(input logic [DW-1:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [DW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    function automatic logic [DW-1:0] phys_rd(input logic [DW-1:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : mem_init(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mem_req"},   bus.mem_req,   0);
        check({tag, "_mem_we"},    bus.mem_we,    0);
        check({tag, "_mem_addr"},  bus.mem_addr,  0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_if_ready"},  bus.if_ready,  0);
        check({tag, "_d_ready"},   bus.d_ready,   0);
        check({tag, "_if_rdata"},  bus.if_rdata,  0);
        check({tag, "_d_rdata"},   bus.d_rdata,   0);
        check({tag, "_bus_error"}, bus_error,     0);
        check({tag, "_stall"},     stall_pipe,    0);
    endtask

    // Memory model: acks each access after a per-access delay taken from delay_q.
    initial begin : responder
        int   wait_cnt;
        int   cur_delay;
        bit   in_acc;
        acc_t a;
        wait_cnt = 0;
        cur_delay = 0;
        in_acc = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            tick();
            bus.mem_ack = force_ack;
            bus.mem_rdata = '0;
            if (ack_en && (bus.mem_req === 1'b1)) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    wait_cnt = 0;
                    cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                end
                if (wait_cnt == cur_delay) begin
                    a.we = bus.mem_we;
                    a.addr = bus.mem_addr;
                    a.wdata = bus.mem_wdata;
                    log_q.push_back(a);
                    bus.mem_ack = 1'b1;
                    if (a.we) begin
                        phys_mem[a.addr] = a.wdata;
                        bus.mem_rdata = $urandom();
                    end else begin
                        bus.mem_rdata = phys_rd(a.addr);
                    end
                    in_acc = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else if (bus.mem_req !== 1'b1) begin
                in_acc = 1'b0;
            end
        end
    end

    // One fetch and/or one data request, each held until its ready pulse.
    task automatic episode(input string tag, input bit f_en, input logic [DW-1:0] f_addr,
                           input bit rd, input bit wr, input logic [DW-1:0] d_addr,
                           input logic [DW-1:0] d_wdata, input int dl1, input int dl2,
                           input bit no_ack);
        bit d_en, d_first, d_chk, exp_stall;
        int f_cyc, d_cyc, first_cyc, second_cyc, last;
        logic [DW-1:0] f_exp, d_exp;
        bit order[$];
        acc_t exp_acc[$];
        acc_t a;
        d_en = rd | wr;
        d_first = d_en && (!f_en || (m_starve < SMAX));
        // The second grant of a pair has no competitor, so the starve count ends at zero.
        m_starve = 0;
        if (d_first) order.push_back(1'b1);
        if (f_en) order.push_back(1'b0);
        if (d_en && !d_first) order.push_back(1'b1);
        first_cyc = 2 + dl1;
        second_cyc = first_cyc + 3 + dl2;
        f_cyc = 0;
        d_cyc = 0;
        d_chk = 1'b0;
        f_exp = '0;
        d_exp = '0;
        foreach (order[k]) begin
            if (order[k]) begin
                d_cyc = (k == 0) ? first_cyc : second_cyc;
                a.we = wr;
                a.addr = d_addr;
                a.wdata = d_wdata;
                if (no_ack) begin
                    d_exp = '0;
                    d_chk = 1'b1;
                end else if (wr) begin
                    d_exp = '0;
                    d_chk = rd;
                    ref_mem[d_addr] = d_wdata;
                end else begin
                    d_exp = ref_rd(d_addr);
                    d_chk = 1'b1;
                end
            end else begin
                f_cyc = (k == 0) ? first_cyc : second_cyc;
                a.we = 1'b0;
                a.addr = f_addr;
                a.wdata = '0;
                f_exp = ref_rd(f_addr);
            end
            if (!no_ack) begin
                exp_acc.push_back(a);
                delay_q.push_back((k == 0) ? dl1 : dl2);
            end
        end

        bus.if_req = f_en;
        bus.if_addr = f_addr;
        bus.d_read = rd;
        bus.d_write = wr;
        bus.d_addr = d_addr;
        bus.d_wdata = d_wdata;
        last = ((f_cyc > d_cyc) ? f_cyc : d_cyc) + 1;
        for (int c = 1; c <= last; c++) begin
            tick();
            if (c == 1) begin
                check({tag, "_req"}, bus.mem_req, 1);
                check({tag, "_addr"}, bus.mem_addr, order[0] ? d_addr : f_addr);
                check({tag, "_we"}, bus.mem_we, order[0] ? wr : 1'b0);
                if (order[0] && wr) check({tag, "_wdata"}, bus.mem_wdata, d_wdata);
            end
            exp_stall = (f_en && (c < f_cyc)) || (d_en && (c < d_cyc));
            check($sformatf("%s_stall_c%0d", tag, c), stall_pipe, exp_stall);
            check($sformatf("%s_if_ready_c%0d", tag, c), bus.if_ready, f_en && (c == f_cyc));
            check($sformatf("%s_d_ready_c%0d", tag, c), bus.d_ready, d_en && (c == d_cyc));
            if (f_en && (c == f_cyc)) begin
                check({tag, "_if_rdata"}, bus.if_rdata, f_exp);
                bus.if_req = 1'b0;
            end
            if (d_en && (c == d_cyc)) begin
                if (d_chk) check({tag, "_d_rdata"}, bus.d_rdata, d_exp);
                bus.d_read = 1'b0;
                bus.d_write = 1'b0;
            end
        end
        check({tag, "_n_acc"}, log_q.size(), exp_acc.size());
        foreach (exp_acc[k]) begin
            if (k < log_q.size()) begin
                check($sformatf("%s_acc%0d_we", tag, k), log_q[k].we, exp_acc[k].we);
                check($sformatf("%s_acc%0d_addr", tag, k), log_q[k].addr, exp_acc[k].addr);
                if (exp_acc[k].we) begin
                    check($sformatf("%s_acc%0d_wdata", tag, k), log_q[k].wdata, exp_acc[k].wdata);
                end
            end
        end
        log_q.delete();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int grants;
        int cyc;
        bit exp_d;

        bus.if_req = 1'b1;
        bus.if_addr = '0;
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;

        // Reset with a pending fetch: outputs quiet, no stall.
        repeat (3) tick();
        check_idle("reset");
        bus.if_req = 1'b0;
        reset = 1'b0;
        tick();
        check_idle("post_reset");

        // Fetch only, ack two cycles after the request.
        phys_mem[32'h40] = 32'h0050_0093;
        ref_mem[32'h40] = 32'h0050_0093;
        episode("fetch", 1'b1, 32'h40, 1'b0, 1'b0, '0, '0, 2, 0, 1'b0);

        // Fetch and load together: data first, fetch after RESP+IDLE.
        phys_mem[32'h1000] = 32'h1234_5678;
        ref_mem[32'h1000] = 32'h1234_5678;
        episode("both", 1'b1, 32'h44, 1'b1, 1'b0, 32'h1000, '0, 0, 1, 1'b0);

        // Continuous stores with a held fetch: every fifth grant goes to fetch.
        m_starve = 0;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h80;
        bus.d_read = 1'b0;
        bus.d_write = 1'b1;
        bus.d_addr = 32'h1040;
        bus.d_wdata = $urandom();
        grants = 0;
        cyc = 0;
        while ((grants < 10) && (cyc < 200)) begin
            tick();
            cyc++;
            if ((bus.if_ready === 1'b1) || (bus.d_ready === 1'b1)) begin
                exp_d = (m_starve < SMAX);
                m_starve = exp_d ? m_starve + 1 : 0;
                check($sformatf("starve_g%0d_d", grants), bus.d_ready, exp_d);
                check($sformatf("starve_g%0d_f", grants), bus.if_ready, !exp_d);
                if (exp_d) begin
                    ref_mem[32'h1040] = bus.d_wdata;
                    bus.d_wdata = $urandom();
                end else begin
                    check($sformatf("starve_g%0d_rdata", grants), bus.if_rdata, ref_rd(32'h80));
                end
                grants++;
                if (grants == 10) begin
                    bus.if_req = 1'b0;
                    bus.d_write = 1'b0;
                end
            end
        end
        check("starve_grants", grants, 10);
        tick();
        log_q.delete();
        m_starve = 0;

        // Load and store together are a store; the load data reads as zero.
        episode("rdwr", 1'b0, '0, 1'b1, 1'b1, 32'h1008, 32'hDEAD_BEEF, 1, 0, 1'b0);
        episode("rdwr_back", 1'b0, '0, 1'b1, 1'b0, 32'h1008, '0, 0, 0, 1'b0);

        // Unacknowledged load times out after TMO request cycles.
        ack_en = 1'b0;
        episode("tmo", 1'b0, '0, 1'b1, 1'b0, 32'h100C, '0, TMO - 1, 0, 1'b1);
        ack_en = 1'b1;
        check("tmo_bus_error", bus_error, 1);
        episode("tmo_after", 1'b1, 32'h48, 1'b0, 1'b0, '0, '0, 0, 0, 1'b0);
        check("tmo_sticky", bus_error, 1);

        // Reset during a data grant, then a late ack.
        ack_en = 1'b0;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h1010;
        tick();
        tick();
        check("rst_mid_req", bus.mem_req, 1);
        reset = 1'b1;
        bus.d_read = 1'b0;
        force_ack = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check_idle("rst_mid_a");
        tick();
        check_idle("rst_mid_b");
        force_ack = 1'b0;
        ack_en = 1'b1;
        tick();
        log_q.delete();

        // Randomized mixes of fetch, load, store and load+store.
        for (int i = 0; i < 40; i++) begin
            int kind;
            bit fe, rd, wr;
            logic [DW-1:0] fa, da, wd;
            kind = $urandom_range(0, 5);
            fe = (kind == 0) || (kind >= 3);
            rd = (kind == 1) || (kind == 3) || (kind == 5);
            wr = (kind == 2) || (kind == 4) || (kind == 5);
            fa = 32'($urandom_range(0, 255)) << 2;
            da = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
            wd = $urandom();
            episode($sformatf("rnd%0d", i), fe, fa, rd, wr, da, wd,
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
